bus_arbiter4: RTL and testbench

- Round-robin arbiter that shares one slave bus port among four masters (CPU data port, DMA, debug, spare).
- Drives the 2-bit select of the shared 4:1 address/data mux and a one-hot grant vector back to the requesters.
- Sits between the master ports and the system bridge. Ownership is held until the slave signals completion; an optional watchdog can force release.

---
 rtl/bus_arbiter4.sv | 111 +++++++++++
 tb/tb_bus_arbiter4.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter sharing one slave port among four masters; owner holds until done or req drop.
// Optional watchdog forced release is compiled in with BUS_ARBITER4_TIMEOUT_EN.
module bus_arbiter4 #(
  parameter int unsigned TO_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] last, last_nxt;
  logic [1:0] sel_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] cand, idx;
  logic       cand_vld;
  logic       wd_hit;
  logic       release_now;

  // Search starts just after the last owner, so the previous owner is considered last.
  always_comb begin
    cand_vld = 1'b0;
    cand     = 2'd0;
    idx      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!cand_vld && req[idx]) begin
        cand_vld = 1'b1;
        cand     = idx;
      end
    end
  end

  assign release_now = (state == OWN) && (done || !req[sel] || wd_hit);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    last_nxt  = last;
    case (state)
      IDLE: begin
        gnt_nxt = 4'b0000;
        if (cand_vld) begin
          gnt_nxt   = 4'b0001 << cand;
          sel_nxt   = cand;
          state_nxt = OWN;
        end
      end
      OWN: begin
        if (release_now) begin
          gnt_nxt   = 4'b0000;
          last_nxt  = sel;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      last  <= 2'd3;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      last  <= last_nxt;
    end
  end

  assign busy = |gnt;

`ifdef BUS_ARBITER4_TIMEOUT_EN
  logic [7:0] cnt;

  // Counter is zero in IDLE, so it starts from zero on every grant.
  assign wd_hit = (state == OWN) && (cnt == 8'(TO_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= 8'd0;
      timeout <= 1'b0;
    end else begin
      timeout <= wd_hit && !done;
      if (state != OWN || release_now) begin
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
`else
  logic unused_to_cycles;

  assign wd_hit           = 1'b0;
  assign timeout          = 1'b0;
  assign unused_to_cycles = ^8'(TO_CYCLES);
`endif

endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4: directed test-plan steps then random traffic against a cycle-level ownership model.
module tb_bus_arbiter4;

  localparam int TO = 4;
`ifdef BUS_ARBITER4_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;

  bus_arbiter4 #(.TO_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, how many cycles it has owned it, and rotation history.
  int m_owner;
  int m_last;
  int m_sel;
  int m_held;
  bit m_to;

  function automatic void model_edge(input logic rst_n, input logic [3:0] r, input logic d);
    m_to = 1'b0;
    if (!rst_n) begin
      m_owner = -1;
      m_last  = 3;
      m_sel   = 0;
      m_held  = 0;
      return;
    end
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (r[c]) begin
          m_owner = c;
          m_sel   = c;
          m_held  = 0;
          break;
        end
      end
    end else begin
      m_held = m_held + 1;
      if (d || (WD_EN && m_held == TO) || !r[m_owner]) begin
        m_to    = WD_EN && (m_held == TO) && !d;
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endfunction

  function automatic logic [3:0] exp_gnt();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic [3:0] r, input logic d);
    reset = rst_n;
    req   = r;
    done  = d;
    model_edge(rst_n, r, d);
    @(posedge clk);
    #1;
    check("gnt", 32'(gnt), 32'(exp_gnt()));
    check("sel", 32'(sel), 32'(m_sel));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_to));
    check("onehot", 32'($onehot0(gnt)), 32'd1);
    check("sel_match", 32'(busy ? gnt[sel] : 1'b1), 32'd1);
  endtask

  int ord [5] = '{0, 1, 2, 3, 0};
  logic [3:0] rr;

  initial begin
    m_owner = -1; m_last = 3; m_sel = 0; m_held = 0; m_to = 1'b0;

    // Reset, single requester, release by done.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    step(1'b1, 4'b0001, 1'b0);
    check("tp1_grant", 32'(gnt), 32'h1);
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0001, 1'b1);
    check("tp1_release", 32'(gnt), 32'h0);
    check("tp1_sel_hold", 32'(sel), 32'h0);
    step(1'b1, 4'b0000, 1'b0);

    // All requesting: rotation 0,1,2,3,0 with an idle gap after each release.
    step(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b1111, 1'b0);
      check("rr_grant", 32'(gnt), 32'(4'b0001 << ord[i]));
      step(1'b1, 4'b1111, 1'b1);
      check("rr_gap", 32'(gnt), 32'h0);
    end

    // Owner 2 with masters 0 and 2 requesting: 2 -> 0 -> 2.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0100, 1'b0);
    check("alt_own2", 32'(gnt), 32'h4);
    step(1'b1, 4'b0101, 1'b1);
    step(1'b1, 4'b0101, 1'b0);
    check("alt_own0", 32'(gnt), 32'h1);
    check("alt_sel0", 32'(sel), 32'h0);
    step(1'b1, 4'b0101, 1'b1);
    step(1'b1, 4'b0101, 1'b0);
    check("alt_sel2", 32'(sel), 32'h2);
    step(1'b1, 4'b0101, 1'b1);

    // Abort by owner 1 with master 3 pending.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    step(1'b1, 4'b1010, 1'b0);
    check("ab_own1", 32'(gnt), 32'h2);
    step(1'b1, 4'b1000, 1'b0);
    check("ab_drop", 32'(gnt), 32'h0);
    check("ab_noto", 32'(timeout), 32'h0);
    step(1'b1, 4'b1000, 1'b0);
    check("ab_sel3", 32'(sel), 32'h3);

    // Reset while master 3 owns the bus.
    step(1'b0, 4'b1000, 1'b0);
    check("rm_gnt", 32'(gnt), 32'h0);
    check("rm_sel", 32'(sel), 32'h0);
    check("rm_busy", 32'(busy), 32'h0);
    step(1'b1, 4'b1000, 1'b0);
    check("rm_regrant", 32'(gnt), 32'h8);
    step(1'b1, 4'b0000, 1'b0);

`ifdef BUS_ARBITER4_TIMEOUT_EN
    // Watchdog: no done for TO owned cycles, then done in the last owned cycle.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 1'b0);
    for (int i = 0; i < TO - 1; i++) step(1'b1, 4'b0001, 1'b0);
    check("wd_held", 32'(gnt), 32'h1);
    step(1'b1, 4'b0001, 1'b0);
    check("wd_drop", 32'(gnt), 32'h0);
    check("wd_pulse", 32'(timeout), 32'h1);
    step(1'b1, 4'b0001, 1'b0);
    check("wd_pulse_end", 32'(timeout), 32'h0);
    for (int i = 0; i < TO - 1; i++) step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0001, 1'b1);
    check("wd_done_wins", 32'(timeout), 32'h0);
    check("wd_done_rel", 32'(gnt), 32'h0);
`endif

    // Random traffic: requests change occasionally, done about a quarter of cycles, rare resets.
    rr = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 49) != 0), rr, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
